multicycle_control_unit: RTL and testbench

Next-generation RV32I control unit for the multi-cycle core: it replaces purely combinational decode with an FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared instruction/data bus with a ready handshake. It drives PC, IR, register-file and bus enables, and detects illegal opcodes and bus timeouts. It also keeps a retired-instruction counter. It sits in the front end between the IR/opcode decode and the datapath/bus.

---
 rtl/multicycle_control_unit.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multi-cycle control FSM with bus handshake, timeout fault and retire counter
//
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK) over a shared
// instruction/data bus. Strobes are decoded from the current state plus
// bus_ready (and, in DECODE/EXECUTE/MEM, the opcode) so bus completion can be
// acted on in the same cycle it is signalled.
//
// Ports:
//   clk, rst       core clock (rising edge), asynchronous active-high reset
//   opcode         instr[6:0] of the IR, valid from DECODE onwards
//   bus_ready      bus completes the current read/write this cycle
//   stall          external hold for DECODE/EXECUTE/WRITEBACK
//   bus_rden       bus read request
//   bus_wren       bus write request
//   bus_addr_sel   0 = PC address, 1 = ALU address
//   ir_wren        load IR from bus read data
//   rf_wren        register-file write enable
//   pc_wren        PC update strobe
//   illegal_instr  one-cycle pulse on an unknown opcode
//   fault          sticky bus-timeout fault
//   state_o        current FSM state, for debug
//   retired_cnt    retired-instruction count

module multicycle_control_unit #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int RETIRE_CNT_W   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              opcode,
   input  logic                    bus_ready,
   input  logic                    stall,
   output logic                    bus_rden,
   output logic                    bus_wren,
   output logic                    bus_addr_sel,
   output logic                    ir_wren,
   output logic                    rf_wren,
   output logic                    pc_wren,
   output logic                    illegal_instr,
   output logic                    fault,
   output logic [2:0]              state_o,
   output logic [RETIRE_CNT_W-1:0] retired_cnt
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Wait counter only has to reach TIMEOUT_CYCLES; it never passes it while
   // the timeout is enabled because hitting the limit leaves the wait state.
   localparam int              WAIT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
   localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              opcode_legal;
   logic              is_store;
   logic              is_mem_op;
   logic              is_branch;
   logic              timeout_hit;

   assign state_o = state;

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
         default:                           opcode_legal = 1'b0;
      endcase
   end

   assign is_store    = (opcode == OP_STORE);
   assign is_mem_op   = (opcode == OP_LOAD) || is_store;
   assign is_branch   = (opcode == OP_BRANCH);
   assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT) && !bus_ready;

   // Strobes: gated by rst so every strobe drops the moment reset asserts,
   // not at the next edge. stall only suppresses the non-bus states.
   always_comb begin
      bus_rden      = 1'b0;
      bus_wren      = 1'b0;
      bus_addr_sel  = 1'b0;
      ir_wren       = 1'b0;
      rf_wren       = 1'b0;
      pc_wren       = 1'b0;
      illegal_instr = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               bus_rden = 1'b1;
               ir_wren  = bus_ready;
            end
            S_DECODE: begin
               if (!stall && !opcode_legal) begin
                  illegal_instr = 1'b1;
                  pc_wren       = 1'b1;
               end
            end
            S_EXECUTE: begin
               if (!stall && is_branch) begin
                  pc_wren = 1'b1;
               end
            end
            S_MEM: begin
               // Only loads and stores reach MEM; anything else is treated as a load.
               bus_addr_sel = 1'b1;
               bus_rden     = !is_store;
               bus_wren     = is_store;
               pc_wren      = is_store && bus_ready;
            end
            S_WRITEBACK: begin
               if (!stall) begin
                  rf_wren = 1'b1;
                  pc_wren = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         wait_cnt    <= '0;
         fault       <= 1'b0;
         retired_cnt <= '0;
      end else begin
         // An illegal skip also strobes pc_wren but is not a retirement.
         if (pc_wren && !illegal_instr) begin
            retired_cnt <= retired_cnt + RETIRE_CNT_W'(1);
         end

         // Counter is held at zero outside FETCH/MEM, which also clears it on
         // every entry into a bus-wait state.
         wait_cnt <= '0;

         case (state)
            S_FETCH: begin
               if (bus_ready) begin
                  state <= S_DECODE;
               end else if (timeout_hit) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               if (!stall) begin
                  state <= opcode_legal ? S_EXECUTE : S_FETCH;
               end
            end
            S_EXECUTE: begin
               if (!stall) begin
                  if (is_mem_op) begin
                     state <= S_MEM;
                  end else if (is_branch) begin
                     state <= S_FETCH;
                  end else begin
                     state <= S_WRITEBACK;
                  end
               end
            end
            S_MEM: begin
               if (bus_ready) begin
                  state <= is_store ? S_FETCH : S_WRITEBACK;
               end else if (timeout_hit) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_WRITEBACK: begin
               if (!stall) begin
                  state <= S_FETCH;
               end
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit

module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        bus_ready;
   logic        stall;
   logic        bus_rden, bus_wren, bus_addr_sel, ir_wren, rf_wren, pc_wren, illegal_instr, fault;
   logic [2:0]  state_o;
   logic [31:0] retired_cnt;

   multicycle_control_unit #(.TIMEOUT_CYCLES(4), .RETIRE_CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .bus_ready(bus_ready), .stall(stall),
      .bus_rden(bus_rden), .bus_wren(bus_wren), .bus_addr_sel(bus_addr_sel),
      .ir_wren(ir_wren), .rf_wren(rf_wren), .pc_wren(pc_wren),
      .illegal_instr(illegal_instr), .fault(fault), .state_o(state_o),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   // Strobe vector order: {bus_rden, bus_wren, bus_addr_sel, ir_wren, rf_wren, pc_wren, illegal_instr}
   localparam logic [6:0] ST_Z   = 7'b0000000;
   localparam logic [6:0] ST_FRD = 7'b1000000;
   localparam logic [6:0] ST_FOK = 7'b1001000;
   localparam logic [6:0] ST_MLD = 7'b1010000;
   localparam logic [6:0] ST_MSW = 7'b0110000;
   localparam logic [6:0] ST_MST = 7'b0110010;
   localparam logic [6:0] ST_WB  = 7'b0000110;
   localparam logic [6:0] ST_BR  = 7'b0000010;
   localparam logic [6:0] ST_ILL = 7'b0000011;

   typedef struct packed {
      logic [15:0] idx;
      logic [2:0]  st;
      logic [6:0]  str;
      logic        flt;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   step_no  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] strobes();
      return {bus_rden, bus_wren, bus_addr_sel, ir_wren, rf_wren, pc_wren, illegal_instr};
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check_eq($sformatf("c%0d.state", e.idx), {29'd0, state_o}, {29'd0, e.st});
         check_eq($sformatf("c%0d.strobes", e.idx), {25'd0, strobes()}, {25'd0, e.str});
         check_eq($sformatf("c%0d.fault", e.idx), {31'd0, fault}, {31'd0, e.flt});
         check_eq($sformatf("c%0d.retired", e.idx), retired_cnt, e.cnt);
      end
   end

   // Drive one cycle's inputs, record what the DUT must show mid-cycle, advance.
   task automatic step(input logic [6:0] op, input logic rdy, input logic stl,
                       input logic [2:0] st, input logic [6:0] str,
                       input logic flt, input logic [31:0] cnt);
      opcode    = op;
      bus_ready = rdy;
      stall     = stl;
      step_no++;
      sb.push_back('{idx: 16'(step_no), st: st, str: str, flt: flt, cnt: cnt});
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".state"}, {29'd0, state_o}, 32'd0);
      check_eq({tag, ".strobes"}, {25'd0, strobes()}, 32'd0);
      check_eq({tag, ".fault"}, {31'd0, fault}, 32'd0);
      check_eq({tag, ".retired"}, retired_cnt, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; opcode = OP_I; bus_ready = 1'b1; stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // ADDI, bus always ready
      step(OP_I, 1, 0, 3'd0, ST_FOK, 0, 0);
      step(OP_I, 1, 0, 3'd1, ST_Z,   0, 0);
      step(OP_I, 1, 0, 3'd2, ST_Z,   0, 0);
      step(OP_I, 1, 0, 3'd4, ST_WB,  0, 0);

      // LW, bus_ready late by 3 cycles in MEM
      step(OP_LOAD, 1, 0, 3'd0, ST_FOK, 0, 1);
      step(OP_LOAD, 1, 0, 3'd1, ST_Z,   0, 1);
      step(OP_LOAD, 1, 0, 3'd2, ST_Z,   0, 1);
      for (int i = 0; i < 3; i++) step(OP_LOAD, 0, 0, 3'd3, ST_MLD, 0, 1);
      step(OP_LOAD, 1, 0, 3'd3, ST_MLD, 0, 1);
      step(OP_LOAD, 1, 0, 3'd4, ST_WB,  0, 1);

      // SW, single-cycle MEM
      step(OP_STORE, 1, 0, 3'd0, ST_FOK, 0, 2);
      step(OP_STORE, 1, 0, 3'd1, ST_Z,   0, 2);
      step(OP_STORE, 1, 0, 3'd2, ST_Z,   0, 2);
      step(OP_STORE, 1, 0, 3'd3, ST_MST, 0, 2);

      // Illegal opcode: skip without retiring
      step(OP_BAD, 1, 0, 3'd0, ST_FOK, 0, 3);
      step(OP_BAD, 1, 0, 3'd1, ST_ILL, 0, 3);

      // BEQ with stall ignored in FETCH and holding EXECUTE for 2 cycles
      step(OP_BRANCH, 1, 1, 3'd0, ST_FOK, 0, 3);
      step(OP_BRANCH, 1, 0, 3'd1, ST_Z,   0, 3);
      step(OP_BRANCH, 1, 1, 3'd2, ST_Z,   0, 3);
      step(OP_BRANCH, 1, 1, 3'd2, ST_Z,   0, 3);
      step(OP_BRANCH, 1, 0, 3'd2, ST_BR,  0, 3);

      // ADDI with stall in DECODE and WRITEBACK
      step(OP_I, 1, 0, 3'd0, ST_FOK, 0, 4);
      step(OP_I, 1, 1, 3'd1, ST_Z,   0, 4);
      step(OP_I, 1, 0, 3'd1, ST_Z,   0, 4);
      step(OP_I, 1, 0, 3'd2, ST_Z,   0, 4);
      step(OP_I, 1, 1, 3'd4, ST_Z,   0, 4);
      step(OP_I, 1, 0, 3'd4, ST_WB,  0, 4);

      // LUI: bus_ready arrives exactly when the wait counter hits the limit
      for (int i = 0; i < 4; i++) step(OP_LUI, 0, 0, 3'd0, ST_FRD, 0, 5);
      step(OP_LUI, 1, 0, 3'd0, ST_FOK, 0, 5);
      step(OP_LUI, 1, 0, 3'd1, ST_Z,   0, 5);
      step(OP_LUI, 1, 0, 3'd2, ST_Z,   0, 5);
      step(OP_LUI, 1, 0, 3'd4, ST_WB,  0, 5);

      // Fetch timeout: 5 waiting cycles, then terminal FAULT
      for (int i = 0; i < 5; i++) step(OP_I, 0, 0, 3'd0, ST_FRD, 0, 6);
      for (int i = 0; i < 3; i++) step(OP_I, 1, 0, 3'd5, ST_Z,   1, 6);

      rst = 1'b1;
      #1;
      check_reset_outputs("fault_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // SW interrupted by reset while the write is pending
      step(OP_STORE, 1, 0, 3'd0, ST_FOK, 0, 0);
      step(OP_STORE, 1, 0, 3'd1, ST_Z,   0, 0);
      step(OP_STORE, 1, 0, 3'd2, ST_Z,   0, 0);
      opcode = OP_STORE; bus_ready = 1'b0; stall = 1'b0;
      step_no++;
      sb.push_back('{idx: 16'(step_no), st: 3'd3, str: ST_MSW, flt: 1'b0, cnt: 32'd0});
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midmem_rst.bus_wren", {31'd0, bus_wren}, 32'd0);
      check_eq("midmem_rst.state", {29'd0, state_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // AUIPC after the restart retires normally from a zero count
      step(OP_AUIPC, 1, 0, 3'd0, ST_FOK, 0, 0);
      step(OP_AUIPC, 1, 0, 3'd1, ST_Z,   0, 0);
      step(OP_AUIPC, 1, 0, 3'd2, ST_Z,   0, 0);
      step(OP_AUIPC, 1, 0, 3'd4, ST_WB,  0, 0);
      step(OP_AUIPC, 0, 0, 3'd0, ST_FRD, 0, 1);

      @(negedge clk);
      #1;
      check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
